tcb_lib_register_buffer: RTL and testbench
==========================================

# tcb_lib_register_buffer

Parametrised request-path buffer for the TCB (Tightly Coupled Bus), placed between a manager and a subordinate to break timing on both the request and the ready paths. Requests are held in a DEPTH-entry circular buffer. `sub.rdy` depends only on local state, so there is no combinational path from `man.rdy` to `sub.rdy`. With DEPTH ≥ 2 it sustains one transfer per cycle. The response path passes through unchanged.

## Interface
Parameters:
- DEPTH, 2, number of request entries; legal range 1..64; any value, not only powers of two.
- GRN, 1, bus hold granularity in bytes; carried for interface compatibility only.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- sub  tcb_if.sub  —  subordinate port; the manager device connects here.
- man  tcb_if.man  —  manager port; the subordinate device connects here.
- cnt  output  $clog2(DEPTH+1)  current number of occupied entries.

## Operation
- Storage: DEPTH entries of `sub.req`; the width is taken from the interface request type.
- Write pointer `wpt` and read pointer `rpt`, each $clog2(DEPTH) bits wide (minimum 1 bit).
  - Each pointer increments on its own handshake.
  - At DEPTH−1 a pointer wraps to 0; the wrap is explicit, with no reliance on power-of-two overflow.
- Push: `sub.vld & sub.rdy`, writes `sub.req` at `wpt`.
- Pop: `man.vld & man.rdy`, advances `rpt`.
- `cnt` update per cycle: +1 on push only, −1 on pop only, unchanged on both or neither.
- `sub.rdy = (cnt != DEPTH)`. It is registered state and never depends on `man.rdy`.
- `man.vld = (cnt != 0)`; `man.req` is the entry at `rpt`.
- Full with a simultaneous pop: the push is refused because `sub.rdy` is 0 that cycle. With DEPTH=1 this gives 50% throughput.
- Empty: `man.req` shows the stale entry and must not be relied on.
- Response: `sub.rsp = man.rsp` combinationally. Response delay is referenced to the `man` handshake; the manager side is built to tolerate the added latency.
- Reset, including mid-operation: `cnt`, `wpt` and `rpt` go to 0 immediately, so `man.vld` = 0 and `sub.rdy` = 1. Entries already buffered are discarded. Storage is not reset.

## Timing
- Latency `sub` → `man` is 1 cycle: a request pushed at edge N is visible on `man` after edge N.
- Throughput: 1 per cycle for DEPTH ≥ 2; 1 per 2 cycles for DEPTH = 1.
- Backpressure: once `man.rdy` = 0, `sub.rdy` falls exactly when `cnt` reaches DEPTH.
  - The buffer absorbs DEPTH requests before stalling the manager.
- `man.vld` and `man.req` are stable while `man.vld & ~man.rdy` (TCB hold rule).

## Configuration
- Macro: TCB_LIB_REGISTER_BUFFER_BYPASS_EN.
- Defined: when `cnt` = 0, the request passes through combinationally.
  - `man.vld = sub.vld`, `man.req = sub.req`.
  - If `man.rdy` = 1, the request completes without occupying an entry (0 latency, no push).
  - If `man.rdy` = 0, the request is pushed as normal.
  - `sub.rdy` keeps its definition and remains free of any combinational path from `man.rdy`.
- Undefined: pure registered behaviour as above, with 1-cycle minimum latency.

## Structure
- Package `tcb_lib_pkg` holds:
  - function `tcb_lib_ptr_inc(ptr, depth)`, the wrap-aware increment;
  - localparam helper `TCB_LIB_CNT_W(depth) = $clog2(depth+1)`.
- Sub-module `tcb_lib_buffer_ctl` holds pointer and count control. Inputs: push, pop. Outputs: wpt, rpt, cnt, full, empty. DEPTH is a parameter.
  - It is reused by later response-path buffers.
- Top level contains only the storage array, the bypass mux and the interface hookup.

## Test plan
- DEPTH=2, `man.rdy`=1, back-to-back requests A0..A7 → `man` shows A0..A7 on consecutive cycles starting 1 cycle after each push; `sub.rdy` stays 1; `cnt` stays 1.
- DEPTH=3, `man.rdy`=0, `sub.vld`=1 → after 3 pushes `cnt`=3 and `sub.rdy`=0. Then release `man.rdy` → order is preserved and `sub.rdy`=1 one cycle after the first pop.
- DEPTH=3, 10 pushes with random `man.rdy` → pointers wrap 2→0 and output order matches input with no loss or duplication; `cnt` matches the scoreboard every cycle.
- DEPTH=1, continuous traffic → a handshake every other cycle on both ports; `sub.rdy` never equals 1 while `cnt`=1.
- `rst` asserted low with `cnt`=2 → `man.vld`=0 and `sub.rdy`=1 without waiting for a clock edge; after deassertion the first new request appears 1 cycle after its push.
- With TCB_LIB_REGISTER_BUFFER_BYPASS_EN defined:
  - `cnt`=0, `man.rdy`=1 → request B appears on `man` in the same cycle and `cnt` stays 0.
  - `man.rdy`=0 → B is pushed and `cnt`=1.

Source files
------------

// File: rtl/tcb_lib_pkg.sv
// Shared TCB library types and helpers: request/response payloads, pointer wrap, count width.
// Pure declarations, no logic of its own.
package tcb_lib_pkg;

    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
    } tcb_rsp_t;

    // Wrap at depth-1 explicitly so non-power-of-two depths work.
    function automatic int unsigned tcb_lib_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned TCB_LIB_CNT_W(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB point-to-point link: valid/ready request channel plus response payload.
interface tcb_if;
    import tcb_lib_pkg::*;

    logic     vld;
    tcb_req_t req;
    logic     rdy;
    tcb_rsp_t rsp;

    modport man (output vld, output req, input rdy, input rsp);
    modport sub (input vld, input req, output rdy, output rsp);
endinterface

// File: rtl/tcb_lib_buffer_ctl.sv
// Circular-buffer pointer and occupancy control for DEPTH entries.
// Latency: state updates on the clock edge after push/pop.
// Backpressure: full/empty are pure functions of registered count; push when full and pop when empty are ignored.
module tcb_lib_buffer_ctl
    import tcb_lib_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = TCB_LIB_CNT_W(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wpt,
    output logic [PTR_W-1:0] rpt,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic push_ok;
    logic pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wpt <= '0;
            rpt <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) begin
                wpt <= PTR_W'(tcb_lib_ptr_inc(32'(wpt), DEPTH));
            end
            if (pop_ok) begin
                rpt <= PTR_W'(tcb_lib_ptr_inc(32'(rpt), DEPTH));
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/tcb_lib_register_buffer.sv
// TCB request-path register buffer, DEPTH entries; response path is a straight wire. Option macro: TCB_LIB_REGISTER_BUFFER_BYPASS_EN.
// Latency: 1 cycle sub->man (0 when bypass enabled and buffer empty with man.rdy high).
// Backpressure: sub.rdy = not full, registered state only; no path from man.rdy.
module tcb_lib_register_buffer
    import tcb_lib_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned GRN   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    tcb_if.sub                         sub,
    tcb_if.man                         man,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // A single-entry buffer still gets a 1-bit pointer, so give it a second slot to index.
    localparam int unsigned MEM_N = (DEPTH > 1) ? DEPTH : 2;

    if (DEPTH == 0 || DEPTH > 64 || GRN == 0) begin : g_bad_param
        $error("tcb_lib_register_buffer: DEPTH must be 1..64 and GRN nonzero");
    end

    logic [PTR_W-1:0] wpt;
    logic [PTR_W-1:0] rpt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    tcb_req_t         mem [MEM_N];

    tcb_lib_buffer_ctl #(
        .DEPTH (DEPTH)
    ) u_ctl (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wpt   (wpt),
        .rpt   (rpt),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wpt] <= sub.req;
        end
    end

    always_comb begin
        sub.rdy = ~full;
        sub.rsp = man.rsp;
`ifdef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
        // Empty buffer forwards the request; it is only stored if the subordinate stalls.
        man.vld = empty ? sub.vld : 1'b1;
        man.req = empty ? sub.req : mem[rpt];
        push    = sub.vld & ~full & ~(empty & man.rdy);
        pop     = ~empty & man.rdy;
`else
        man.vld = ~empty;
        man.req = mem[rpt];
        push    = sub.vld & ~full;
        pop     = ~empty & man.rdy;
`endif
    end

endmodule

// File: tb/tb_tcb_lib_register_buffer.sv
// Directed checks of tcb_lib_register_buffer at DEPTH 2, 3 and 1.
module tb_tcb_lib_register_buffer;
    import tcb_lib_pkg::*;

    localparam logic [31:0] A0 = 32'h100;
    localparam logic [31:0] C0 = 32'h300;
    localparam logic [31:0] D0 = 32'h400;
    localparam logic [31:0] E0 = 32'h500;
    localparam logic [31:0] F0 = 32'h600;
`ifdef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
    localparam logic [31:0] B0 = 32'hB00;
`else
    localparam logic [31:0] G0 = 32'h700;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cnt2;
    logic [1:0] cnt3;
    logic [0:0] cnt1;

    int n_vec = 0;
    int n_err = 0;

    tcb_if s2 (); tcb_if m2 ();
    tcb_if s3 (); tcb_if m3 ();
    tcb_if s1 (); tcb_if m1 ();

    tcb_lib_register_buffer #(.DEPTH(2), .GRN(1)) u_d2 (.clk(clk), .rst(rst), .sub(s2), .man(m2), .cnt(cnt2));
    tcb_lib_register_buffer #(.DEPTH(3), .GRN(1)) u_d3 (.clk(clk), .rst(rst), .sub(s3), .man(m3), .cnt(cnt3));
    tcb_lib_register_buffer #(.DEPTH(1), .GRN(1)) u_d1 (.clk(clk), .rst(rst), .sub(s1), .man(m1), .cnt(cnt1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic tcb_req_t mk(input logic [31:0] a);
        tcb_req_t r;
        r.wen = 1'b1;
        r.adr = a;
        r.ben = 4'hF;
        r.wdt = ~a;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          k;
        int          mc;
        int          popped;
        int          q[$];
        logic [39:0] pat;
        logic        exp_vld;
        logic [31:0] exp_adr;
        logic        mpush;

        s2.vld = 1'b0; s2.req = mk(32'h0); m2.rdy = 1'b0; m2.rsp = '0;
        s3.vld = 1'b0; s3.req = mk(32'h0); m3.rdy = 1'b0; m3.rsp = '0;
        s1.vld = 1'b0; s1.req = mk(32'h0); m1.rdy = 1'b0; m1.rsp = '0;
        #12 rst = 1'b1;
        next_cycle();

        // reset state and response pass-through
        m2.rsp = '{rdt: 32'hCAFE_F00D, err: 1'b1};
        @(negedge clk);
        chk("rst_cnt2", 32'(cnt2), 32'd0);
        chk("rst_vld2", 32'(m2.vld), 32'd0);
        chk("rst_rdy2", 32'(s2.rdy), 32'd1);
        chk("rst_cnt3", 32'(cnt3), 32'd0);
        chk("rst_rdy1", 32'(s1.rdy), 32'd1);
        chk("rsp_rdt", s2.rsp.rdt, 32'hCAFE_F00D);
        chk("rsp_err", 32'(s2.rsp.err), 32'd1);
        next_cycle();

`ifndef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
        // DEPTH=2 streaming, man.rdy held high
        m2.rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s2.vld = 1'b1;
            s2.req = mk(A0 + 32'(i));
            @(negedge clk);
            chk("t1_sub_rdy", 32'(s2.rdy), 32'd1);
            if (i == 0) begin
                chk("t1_vld_first", 32'(m2.vld), 32'd0);
            end else begin
                chk("t1_vld", 32'(m2.vld), 32'd1);
                chk("t1_adr", m2.req.adr, A0 + 32'(i) - 32'd1);
                chk("t1_cnt", 32'(cnt2), 32'd1);
            end
            next_cycle();
        end
        s2.vld = 1'b0;
        @(negedge clk);
        chk("t1_last_adr", m2.req.adr, A0 + 32'd7);
        chk("t1_last_wdt", m2.req.wdt, ~(A0 + 32'd7));
        next_cycle();
        @(negedge clk);
        chk("t1_drain_vld", 32'(m2.vld), 32'd0);
        chk("t1_drain_cnt", 32'(cnt2), 32'd0);
        next_cycle();
`endif

        // DEPTH=3 fill with man.rdy low, then release
        m3.rdy = 1'b0;
        s3.vld = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            s3.req = mk(C0 + 32'(k));
            @(negedge clk);
            chk("t2_cnt", 32'(cnt3), (i < 3) ? 32'(i) : 32'd3);
            chk("t2_sub_rdy", 32'(s3.rdy), 32'(i < 3));
            if (i > 0) begin
                chk("t2_hold_adr", m3.req.adr, C0);
            end
            if (i < 3) k++;
            next_cycle();
        end
        s3.vld = 1'b0;
        m3.rdy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t2_order", m3.req.adr, C0 + 32'(j));
            chk("t2_rdy_rel", 32'(s3.rdy), 32'(j != 0));
            chk("t2_cnt_rel", 32'(cnt3), 32'(3 - j));
            next_cycle();
        end
        @(negedge clk);
        chk("t2_empty_vld", 32'(m3.vld), 32'd0);
        next_cycle();

        // DEPTH=3, ten pushes against an irregular man.rdy pattern, scoreboarded
        pat    = 40'hFF_FFC6_B52D;
        k      = 0;
        popped = 0;
        q.delete();
        for (int c = 0; c < 40; c++) begin
            s3.vld = (k < 10);
            s3.req = mk(D0 + 32'(k));
            m3.rdy = pat[c];
            @(negedge clk);
`ifdef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
            exp_vld = (q.size() != 0) || s3.vld;
            exp_adr = (q.size() != 0) ? 32'(q[0]) : D0 + 32'(k);
`else
            exp_vld = (q.size() != 0);
            exp_adr = (q.size() != 0) ? 32'(q[0]) : 32'd0;
`endif
            chk("t3_cnt", 32'(cnt3), 32'(q.size()));
            chk("t3_sub_rdy", 32'(s3.rdy), 32'(q.size() != 3));
            chk("t3_vld", 32'(m3.vld), 32'(exp_vld));
            if (exp_vld) begin
                chk("t3_adr", m3.req.adr, exp_adr);
            end
            mpush = s3.vld && (q.size() != 3);
`ifdef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
            if (q.size() == 0 && s3.vld && m3.rdy) begin
                popped++;
                k++;
                mpush = 1'b0;
            end else
`endif
            if (exp_vld && m3.rdy) begin
                void'(q.pop_front());
                popped++;
            end
            if (mpush) begin
                q.push_back(int'(D0) + k);
                k++;
            end
            next_cycle();
        end
        chk("t3_delivered", 32'(popped), 32'd10);
        s3.vld = 1'b0;
        m3.rdy = 1'b0;

`ifndef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
        // DEPTH=1 continuous traffic: handshake every other cycle
        m1.rdy = 1'b1;
        s1.vld = 1'b1;
        mc = 0;
        k  = 0;
        for (int i = 0; i < 10; i++) begin
            s1.req = mk(E0 + 32'(k));
            @(negedge clk);
            chk("t4_cnt", 32'(cnt1), 32'(mc));
            chk("t4_sub_rdy", 32'(s1.rdy), 32'(mc == 0));
            chk("t4_vld", 32'(m1.vld), 32'(mc == 1));
            if (mc == 1) begin
                chk("t4_adr", m1.req.adr, E0 + 32'(k) - 32'd1);
            end
            if (mc == 0) begin
                mc = 1;
                k++;
            end else begin
                mc = 0;
            end
            next_cycle();
        end
        s1.vld = 1'b0;
`endif

        // asynchronous reset with two entries held
        m3.rdy = 1'b0;
        s3.vld = 1'b1;
        s3.req = mk(F0);
        next_cycle();
        s3.req = mk(F0 + 32'd1);
        next_cycle();
        s3.vld = 1'b0;
        @(negedge clk);
        chk("t5_cnt_pre", 32'(cnt3), 32'd2);
        #1 rst = 1'b0;
        #1;
        chk("t5_cnt_rst", 32'(cnt3), 32'd0);
        chk("t5_vld_rst", 32'(m3.vld), 32'd0);
        chk("t5_rdy_rst", 32'(s3.rdy), 32'd1);
        #1 rst = 1'b1;
        next_cycle();

`ifndef TCB_LIB_REGISTER_BUFFER_BYPASS_EN
        s3.vld = 1'b1;
        s3.req = mk(G0);
        m3.rdy = 1'b1;
        @(negedge clk);
        chk("t5_vld_before", 32'(m3.vld), 32'd0);
        next_cycle();
        s3.vld = 1'b0;
        @(negedge clk);
        chk("t5_vld_after", 32'(m3.vld), 32'd1);
        chk("t5_adr_after", m3.req.adr, G0);
        chk("t5_cnt_after", 32'(cnt3), 32'd1);
        next_cycle();
`else
        // bypass: empty buffer forwards in the same cycle
        s3.vld = 1'b1;
        s3.req = mk(B0);
        m3.rdy = 1'b1;
        @(negedge clk);
        chk("byp_vld", 32'(m3.vld), 32'd1);
        chk("byp_adr", m3.req.adr, B0);
        chk("byp_cnt", 32'(cnt3), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("byp_cnt_after", 32'(cnt3), 32'd0);
        m3.rdy = 1'b0;
        s3.req = mk(B0 + 32'd1);
        #1;
        chk("byp_stall_adr", m3.req.adr, B0 + 32'd1);
        next_cycle();
        s3.vld = 1'b0;
        @(negedge clk);
        chk("byp_push_cnt", 32'(cnt3), 32'd1);
        chk("byp_push_adr", m3.req.adr, B0 + 32'd1);
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
